// File: rtl/asip_modmul_pkg.sv
// Shared types and sizes for the execute-stage modular-multiply unit.
package asip_modmul_pkg;

   localparam int MODMUL_N = 32;
   localparam int REG_W    = 5;

   typedef enum logic [1:0] {
      MM_IDLE,
      MM_RUN,
      MM_DONE
   } modmul_state_t;

endpackage

// File: rtl/ex_modmul_unit_step.sv
// One interleaved modmul iteration: R' = reduce(reduce(2R + bit*opb)).
// Inputs must satisfy R < n and opb < n, so two conditional subtractions suffice.
module modmul_step #(
   parameter int N = 32
) (
   input  logic [N+1:0] r_i,
   input  logic [N-1:0] opb_i,
   input  logic [N-1:0] n_i,
   input  logic         bit_i,
   output logic [N+1:0] r_o
);

   logic [N+1:0] n_ext;
   logic [N+1:0] dbl;
   logic [N+1:0] sum;
   logic [N+1:0] red1;

   // 2R + opb < 3n < 2^(N+2), so N+2 bits never overflow
   assign n_ext = {2'b00, n_i};
   assign dbl   = {r_i[N:0], 1'b0};
   assign sum   = bit_i ? (dbl + {2'b00, opb_i}) : dbl;
   assign red1  = (sum >= n_ext) ? (sum - n_ext) : sum;
   assign r_o   = (red1 >= n_ext) ? (red1 - n_ext) : red1;

endmodule

// File: rtl/ex_modmul_unit.sv
// Execute-stage RSA modular multiply: (opa*opb) mod modulus, one opa bit per cycle, MSB first.
// Optional MODMUL_ZERO_SKIP_EN starts at the MSB of opa instead of bit N-1.
module ex_modmul_unit
   import asip_modmul_pkg::*;
#(
   parameter int N     = MODMUL_N,
   parameter int CNT_W = $clog2(N) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [N-1:0]     opa,
   input  logic [N-1:0]     opb,
   input  logic [N-1:0]     modulus,
   input  logic [REG_W-1:0] rw_in,
   input  logic             wr_en_in,
   output logic             stall,
   output logic             done,
   output logic [N-1:0]     result,
   output logic [REG_W-1:0] rw_out,
   output logic             wr_en_out,
   output logic             div_err
);

   localparam int IDX_W = CNT_W - 1;

   modmul_state_t    state_q;
   logic [N+1:0]     r_q;
   logic [N+1:0]     r_d;
   logic [N-1:0]     opa_q;
   logic [N-1:0]     opb_q;
   logic [N-1:0]     n_q;
   logic [REG_W-1:0] rw_q;
   logic             wr_en_q;
   logic [CNT_W-1:0] idx_q;
   logic             done_q;
   logic [N-1:0]     result_q;
   logic [REG_W-1:0] rw_out_q;
   logic             wr_en_out_q;
   logic             div_err_q;

   logic [CNT_W-1:0] start_idx;
   logic             skip_all;
   logic             div_zero;

`ifdef MODMUL_ZERO_SKIP_EN
   // Priority encoder: highest set bit of opa wins
   always_comb begin
      start_idx = '0;
      for (int i = 0; i < N; i++)
         if (opa[i]) start_idx = CNT_W'(i);
   end
   assign skip_all = (opa == '0);
`else
   assign start_idx = CNT_W'(N - 1);
   assign skip_all  = 1'b0;
`endif

   assign div_zero = (modulus == '0);

   modmul_step #(.N(N)) u_step (
      .r_i   (r_q),
      .opb_i (opb_q),
      .n_i   (n_q),
      .bit_i (opa_q[idx_q[IDX_W-1:0]]),
      .r_o   (r_d)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= MM_IDLE;
         r_q         <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         n_q         <= '0;
         rw_q        <= '0;
         wr_en_q     <= 1'b0;
         idx_q       <= '0;
         done_q      <= 1'b0;
         result_q    <= '0;
         rw_out_q    <= '0;
         wr_en_out_q <= 1'b0;
         div_err_q   <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         wr_en_out_q <= 1'b0;
         case (state_q)
            MM_IDLE, MM_DONE: begin
               if (start) begin
                  opa_q   <= opa;
                  opb_q   <= opb;
                  n_q     <= modulus;
                  rw_q    <= rw_in;
                  wr_en_q <= wr_en_in;
                  r_q     <= '0;
                  idx_q   <= start_idx;
                  // Degenerate ops finish without iterating; a zero modulus suppresses the write
                  if (div_zero || skip_all) begin
                     state_q     <= MM_DONE;
                     done_q      <= 1'b1;
                     result_q    <= '0;
                     rw_out_q    <= rw_in;
                     wr_en_out_q <= wr_en_in && !div_zero;
                     div_err_q   <= div_zero;
                  end else begin
                     state_q <= MM_RUN;
                  end
               end else begin
                  state_q <= MM_IDLE;
               end
            end
            MM_RUN: begin
               r_q   <= r_d;
               idx_q <= idx_q - 1'b1;
               if (idx_q == '0) begin
                  state_q     <= MM_DONE;
                  done_q      <= 1'b1;
                  result_q    <= r_d[N-1:0];
                  rw_out_q    <= rw_q;
                  wr_en_out_q <= wr_en_q;
                  div_err_q   <= 1'b0;
               end
            end
            default: state_q <= MM_IDLE;
         endcase
      end
   end

   // Hold the front end on the issue cycle and for the whole iteration
   assign stall     = (start && (state_q != MM_RUN)) || (state_q == MM_RUN);
   assign done      = done_q;
   assign result    = result_q;
   assign rw_out    = rw_out_q;
   assign wr_en_out = wr_en_out_q;
   assign div_err   = div_err_q;

endmodule

// File: tb/tb_ex_modmul_unit.sv
// Self-checking bench for ex_modmul_unit; expected values come from 64-bit (a*b)%n arithmetic.
module tb_ex_modmul_unit;

   localparam int N = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [N-1:0]  opa, opb, modulus;
   logic [4:0]    rw_in;
   logic          wr_en_in;
   logic          stall, done, wr_en_out, div_err;
   logic [N-1:0]  result;
   logic [4:0]    rw_out;

   int n_checks = 0;
   int n_fail   = 0;

   ex_modmul_unit dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .opa       (opa),
      .opb       (opb),
      .modulus   (modulus),
      .rw_in     (rw_in),
      .wr_en_in  (wr_en_in),
      .stall     (stall),
      .done      (done),
      .result    (result),
      .rw_out    (rw_out),
      .wr_en_out (wr_en_out),
      .div_err   (div_err)
   );

   always #5 clock = ~clock;

   function automatic logic [N-1:0] ref_mod(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] n);
      logic [63:0] p;
      if (n == '0) return '0;
      p = 64'(a) * 64'(b);
      return 32'(p % 64'(n));
   endfunction

   // Cycles from the accepting edge to the negedge where done is seen
   function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] n);
      if (n == '0) return 1;
`ifdef MODMUL_ZERO_SKIP_EN
      for (int i = N - 1; i >= 0; i--)
         if (a[i]) return i + 2;
      return 1;
`else
      if (a == '0) return N + 1;
      return N + 1;
`endif
   endfunction

   // Called at a negedge: present an op with start high
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] n,
                        input logic [4:0] rw, input logic we);
      opa = a; opb = b; modulus = n; rw_in = rw; wr_en_in = we; start = 1'b1;
      #1;
   endtask

   // Drops start after the accepting edge and waits (bounded) for done
   task automatic wait_done(output int cyc, output int stall_lo);
      @(negedge clock);
      start = 1'b0;
      cyc = 1;
      stall_lo = 0;
      while (done !== 1'b1 && cyc < 200) begin
         if (stall !== 1'b1) stall_lo++;
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0;
      opa = '0; opb = '0; modulus = '0; rw_in = '0; wr_en_in = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++; if ({done, stall, wr_en_out, div_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {done, stall, wr_en_out, div_err}); end
      n_checks++; if (result !== '0 || rw_out !== '0) begin n_fail++; $display("FAIL reset_data: got result=%h rw=%0d want 0", result, rw_out); end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic();
      int cyc, slo;
      issue(7, 9, 13, 5, 1'b1);
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL basic_issue_stall: got %b want 1", stall); end
      wait_done(cyc, slo);
      n_checks++; if (cyc !== exp_lat(7, 13)) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", cyc, exp_lat(7, 13)); end
      n_checks++; if (result !== 32'd11) begin n_fail++; $display("FAIL basic_result: got %0d want 11", result); end
      n_checks++; if (rw_out !== 5'd5 || wr_en_out !== 1'b1 || div_err !== 1'b0) begin n_fail++; $display("FAIL basic_tag: got rw=%0d we=%b err=%b want 5 1 0", rw_out, wr_en_out, div_err); end
      n_checks++; if (slo !== 0 || stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall: got low_in_run=%0d done_stall=%b want 0 0", slo, stall); end
      @(negedge clock);
      n_checks++; if (done !== 1'b0 || wr_en_out !== 1'b0 || result !== 32'd11) begin n_fail++; $display("FAIL basic_after: got done=%b we=%b result=%0d want 0 0 11", done, wr_en_out, result); end
   endtask

   task automatic test_wide();
      int cyc, slo;
      issue(32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 3, 1'b1);
      wait_done(cyc, slo);
      n_checks++; if (result !== 32'd1) begin n_fail++; $display("FAIL wide_result: got %h want 1", result); end
      n_checks++; if (cyc !== exp_lat(32'hFFFF_FFFA, 32'hFFFF_FFFB)) begin n_fail++; $display("FAIL wide_latency: got %0d want %0d", cyc, exp_lat(32'hFFFF_FFFA, 32'hFFFF_FFFB)); end
      @(negedge clock);
   endtask

   task automatic test_div_zero();
      int cyc, slo;
      issue(3, 4, 0, 9, 1'b1);
      wait_done(cyc, slo);
      n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d want 1", cyc); end
      n_checks++; if (result !== '0 || div_err !== 1'b1 || wr_en_out !== 1'b0) begin n_fail++; $display("FAIL div0_out: got result=%0d err=%b we=%b want 0 1 0", result, div_err, wr_en_out); end
      n_checks++; if (rw_out !== 5'd9) begin n_fail++; $display("FAIL div0_tag: got %0d want 9", rw_out); end
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      int cyc, slo;
      issue(7, 9, 13, 5, 1'b1);
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      n_checks++; if ({done, stall, wr_en_out, div_err} !== 4'b0 || result !== '0 || rw_out !== '0) begin n_fail++; $display("FAIL midreset_out: got flags=%b result=%0d rw=%0d want 0", {done, stall, wr_en_out, div_err}, result, rw_out); end
      reset = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++; if (done !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got done=%b stall=%b want 0 0", done, stall); end
      issue(2, 3, 5, 1, 1'b1);
      wait_done(cyc, slo);
      n_checks++; if (result !== 32'd1 || cyc !== exp_lat(2, 5)) begin n_fail++; $display("FAIL midreset_next: got result=%0d lat=%0d want 1 %0d", result, cyc, exp_lat(2, 5)); end
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      int cyc, slo;
      issue(7, 9, 13, 5, 1'b1);
      wait_done(cyc, slo);
      n_checks++; if (result !== 32'd11) begin n_fail++; $display("FAIL b2b_first: got %0d want 11", result); end
      issue(4, 5, 7, 6, 1'b1);
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_done_stall: got %b want 1", stall); end
      wait_done(cyc, slo);
      n_checks++; if (result !== 32'd6 || rw_out !== 5'd6) begin n_fail++; $display("FAIL b2b_second: got result=%0d rw=%0d want 6 6", result, rw_out); end
      n_checks++; if (cyc !== exp_lat(4, 7) || slo !== 0) begin n_fail++; $display("FAIL b2b_timing: got lat=%0d stall_lo=%0d want %0d 0", cyc, slo, exp_lat(4, 7)); end
      @(negedge clock);
   endtask

   task automatic test_small_opa();
      int cyc, slo;
      issue(1, 5, 7, 2, 1'b1);
      wait_done(cyc, slo);
      n_checks++; if (result !== 32'd5 || cyc !== exp_lat(1, 7)) begin n_fail++; $display("FAIL one_opa: got result=%0d lat=%0d want 5 %0d", result, cyc, exp_lat(1, 7)); end
      @(negedge clock);
      issue(0, 12, 13, 4, 1'b1);
      wait_done(cyc, slo);
      n_checks++; if (result !== '0 || cyc !== exp_lat(0, 13) || wr_en_out !== 1'b1) begin n_fail++; $display("FAIL zero_opa: got result=%0d lat=%0d we=%b want 0 %0d 1", result, cyc, wr_en_out, exp_lat(0, 13)); end
      @(negedge clock);
      issue(12, 0, 13, 4, 1'b0);
      wait_done(cyc, slo);
      n_checks++; if (result !== '0 || cyc !== exp_lat(12, 13) || wr_en_out !== 1'b0) begin n_fail++; $display("FAIL zero_opb: got result=%0d lat=%0d we=%b want 0 %0d 0", result, cyc, wr_en_out, exp_lat(12, 13)); end
      @(negedge clock);
   endtask

   task automatic test_random();
      int cyc, slo;
      logic [N-1:0] a, b, n;
      logic [4:0]   rw;
      logic         we;
      for (int k = 0; k < 24; k++) begin
         n  = (k % 3 == 0) ? N'($urandom_range(1, 1000)) : ($urandom() | 32'h1);
         a  = $urandom() % n;
         b  = $urandom() % n;
         if (k % 8 == 5) a = n - 1;
         rw = 5'($urandom());
         we = 1'($urandom());
         issue(a, b, n, rw, we);
         wait_done(cyc, slo);
         n_checks++;
         if (result !== ref_mod(a, b, n) || rw_out !== rw || wr_en_out !== we || div_err !== 1'b0 || cyc !== exp_lat(a, n)) begin
            n_fail++;
            $display("FAIL rand_%0d: a=%h b=%h n=%h got r=%h rw=%0d we=%b err=%b lat=%0d want r=%h rw=%0d we=%b err=0 lat=%0d",
                     k, a, b, n, result, rw_out, wr_en_out, div_err, cyc, ref_mod(a, b, n), rw, we, exp_lat(a, n));
         end
         if (k % 2 == 0) @(negedge clock);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wide();
      test_div_zero();
      test_reset_mid();
      test_back_to_back();
      test_small_opa();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
